// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor.
//
// Sits on the consuming side of the core clock PLL and runs from refclk, so it keeps working
// while the PLL outputs are absent. It pulses the PLL reset and waits for lock. It then requires
// lock to be held continuously before releasing the core's active-low system reset. A lock
// timeout retries the PLL, and a loss of lock while running re-sequences from the PLL reset.
//
// Ports:
//   refclk      in   board reference clock (also feeds the PLL)
//   rst_n       in   asynchronous active-low reset
//   locked      in   PLL lock, asynchronous to refclk
//   force_reset in   level request to restart the PLL; highest priority
//   pll_rst     out  PLL reset, active high, registered
//   sys_reset_n out  core reset, active low, registered; high only in RUN
//   ready       out  high only in RUN, registered
//   lock_lost   out  one-cycle pulse when lock drops while in RUN
//   retry_cnt   out  count of lock-timeout retries, saturating at 255
module pll_lock_supervisor #(
  parameter int unsigned RST_PULSE    = 16,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned LOCK_TIMEOUT = 50000,
  parameter int unsigned CNT_W        = 20
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       force_reset,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] retry_cnt
);

  typedef enum logic [1:0] {
    StPllRst   = 2'd0,
    StWaitLock = 2'd1,
    StStable   = 2'd2,
    StRun      = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] RstLast     = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0] StableLast  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntOne      = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_locked_meta;
  logic             r_locked_s;
  logic             r_pll_rst;
  logic             r_run;
  logic             r_lock_lost;
  logic             w_lock_lost_next;
  logic [7:0]       r_retry;
  logic [7:0]       w_retry_next;
  logic             w_retry_inc;

  // Two-flop synchronizer; nothing downstream looks at raw 'locked'.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_locked_meta <= 1'b0;
      r_locked_s    <= 1'b0;
    end else begin
      r_locked_meta <= locked;
      r_locked_s    <= r_locked_meta;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_retry_inc      = 1'b0;
    w_lock_lost_next = 1'b0;

    if (force_reset) begin
      // Overrides lock loss and timeout alike: no retry count, no lock_lost pulse.
      w_state_next = StPllRst;
    end else begin
      case (r_state)
        StPllRst: begin
          if (r_cnt == RstLast) w_state_next = StWaitLock;
        end
        StWaitLock: begin
          if (r_locked_s) begin
            w_state_next = StStable;
          end else if (r_cnt == TimeoutLast) begin
            w_state_next = StPllRst;
            w_retry_inc  = 1'b1;
          end
        end
        StStable: begin
          // A drop here is treated as a glitch: back to waiting with a fresh timeout.
          if (!r_locked_s) begin
            w_state_next = StWaitLock;
          end else if (r_cnt == StableLast) begin
            w_state_next = StRun;
          end
        end
        StRun: begin
          if (!r_locked_s) begin
            w_state_next     = StPllRst;
            w_lock_lost_next = 1'b1;
          end
        end
        default: w_state_next = StPllRst;
      endcase
    end

    // Counter restarts on every state entry, including a held force_reset in PLL_RST.
    // It is not needed in RUN, so it is frozen there.
    if (force_reset || (w_state_next != r_state)) begin
      w_cnt_next = '0;
    end else if (r_state == StRun) begin
      w_cnt_next = r_cnt;
    end else begin
      w_cnt_next = r_cnt + CntOne;
    end

    if (w_retry_inc && (r_retry != 8'hFF)) begin
      w_retry_next = r_retry + 8'd1;
    end else begin
      w_retry_next = r_retry;
    end
  end

  // Outputs are decoded from the next state so each flop matches the registered state.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StPllRst;
      r_cnt       <= '0;
      r_pll_rst   <= 1'b1;
      r_run       <= 1'b0;
      r_lock_lost <= 1'b0;
      r_retry     <= 8'd0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_pll_rst   <= (w_state_next == StPllRst);
      r_run       <= (w_state_next == StRun);
      r_lock_lost <= w_lock_lost_next;
      r_retry     <= w_retry_next;
    end
  end

  assign pll_rst     = r_pll_rst;
  assign sys_reset_n = r_run;
  assign ready       = r_run;
  assign lock_lost   = r_lock_lost;
  assign retry_cnt   = r_retry;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed testbench for pll_lock_supervisor with RST_PULSE=4, LOCK_STABLE=8, LOCK_TIMEOUT=32.
// Inputs change and outputs are sampled on the falling edge of refclk.
module tb_pll_lock_supervisor;

  localparam int unsigned RP = 4;
  localparam int unsigned LS = 8;
  localparam int unsigned LT = 32;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       locked;
  logic       force_reset;
  logic       pll_rst;
  logic       sys_reset_n;
  logic       ready;
  logic       lock_lost;
  logic [7:0] retry_cnt;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  pll_lock_supervisor #(
    .RST_PULSE   (RP),
    .LOCK_STABLE (LS),
    .LOCK_TIMEOUT(LT),
    .CNT_W       (20)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .locked     (locked),
    .force_reset(force_reset),
    .pll_rst    (pll_rst),
    .sys_reset_n(sys_reset_n),
    .ready      (ready),
    .lock_lost  (lock_lost),
    .retry_cnt  (retry_cnt)
  );

  always #5 refclk = ~refclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge refclk);
    @(negedge refclk);
  endtask

  // Reset with locked low, then wait out the 4-cycle PLL reset pulse.
  task automatic reset_and_release();
    rst_n       = 1'b0;
    locked      = 1'b0;
    force_reset = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (RP) tick();
  endtask

  task automatic bring_to_run();
    reset_and_release();
    locked = 1'b1;
    repeat (LS + 3) tick();
    n_vec++;
    if (ready !== 1'b1) begin
      n_err++;
      $display("FAIL run_entry_ready: got %b want 1", ready);
    end
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    locked      = 1'b1;
    force_reset = 1'b0;
    repeat (3) tick();
    n_vec++;
    if (pll_rst !== 1'b1) begin n_err++; $display("FAIL reset_pll_rst: got %b want 1", pll_rst); end
    n_vec++;
    if (sys_reset_n !== 1'b0) begin
      n_err++; $display("FAIL reset_sys_reset_n: got %b want 0", sys_reset_n);
    end
    n_vec++;
    if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", ready); end
    n_vec++;
    if (lock_lost !== 1'b0) begin n_err++; $display("FAIL reset_lock_lost: got %b want 0", lock_lost); end
    n_vec++;
    if (retry_cnt !== 8'd0) begin n_err++; $display("FAIL reset_retry: got %0d want 0", retry_cnt); end
    locked = 1'b0;
    rst_n  = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_vec++;
      if (pll_rst !== logic'(k < 4)) begin
        n_err++;
        $display("FAIL reset_pulse_len cycle %0d: got %b want %b", k, pll_rst, logic'(k < 4));
      end
    end
  endtask

  // Continues from test_reset: pll_rst has just fallen.
  task automatic test_clean_lock();
    repeat (10) tick();
    locked = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      n_vec++;
      if (sys_reset_n !== logic'(k == 11) || ready !== logic'(k == 11)) begin
        n_err++;
        $display("FAIL clean_lock_release edge %0d: got sys_reset_n=%b ready=%b want %b",
                 k, sys_reset_n, ready, logic'(k == 11));
      end
    end
    n_vec++;
    if (retry_cnt !== 8'd0) begin n_err++; $display("FAIL clean_lock_retry: got %0d want 0", retry_cnt); end
  endtask

  // Continues from test_clean_lock: in RUN.
  task automatic test_lock_loss();
    locked = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      n_vec++;
      if (sys_reset_n !== logic'(k < 3) || ready !== logic'(k < 3)) begin
        n_err++;
        $display("FAIL loss_sys_reset edge %0d: got sys_reset_n=%b ready=%b want %b",
                 k, sys_reset_n, ready, logic'(k < 3));
      end
      n_vec++;
      if (pll_rst !== logic'(k >= 3 && k <= 6)) begin
        n_err++;
        $display("FAIL loss_pll_rst edge %0d: got %b want %b", k, pll_rst, logic'(k >= 3 && k <= 6));
      end
      n_vec++;
      if (lock_lost !== logic'(k == 3)) begin
        n_err++;
        $display("FAIL loss_pulse edge %0d: got %b want %b", k, lock_lost, logic'(k == 3));
      end
    end
    locked = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      n_vec++;
      if (sys_reset_n !== logic'(k == 11)) begin
        n_err++;
        $display("FAIL relock_release edge %0d: got %b want %b", k, sys_reset_n, logic'(k == 11));
      end
    end
    n_vec++;
    if (retry_cnt !== 8'd0) begin n_err++; $display("FAIL loss_retry: got %0d want 0", retry_cnt); end
  endtask

  // locked: high for samples 1-5, low for sample 6, then high again.
  task automatic test_glitch();
    reset_and_release();
    for (int k = 1; k <= 17; k++) begin
      locked = logic'(k != 6);
      tick();
      n_vec++;
      if (sys_reset_n !== logic'(k == 17)) begin
        n_err++;
        $display("FAIL glitch_release edge %0d: got %b want %b", k, sys_reset_n, logic'(k == 17));
      end
      n_vec++;
      if (pll_rst !== 1'b0) begin
        n_err++;
        $display("FAIL glitch_pll_rst edge %0d: got %b want 0", k, pll_rst);
      end
    end
    n_vec++;
    if (retry_cnt !== 8'd0) begin n_err++; $display("FAIL glitch_retry: got %0d want 0", retry_cnt); end
  endtask

  task automatic test_no_lock();
    reset_and_release();
    for (int k = 1; k <= 36; k++) begin
      tick();
      n_vec++;
      if (pll_rst !== logic'(k >= 32 && k <= 35)) begin
        n_err++;
        $display("FAIL nolock_period cycle %0d: got %b want %b", k, pll_rst, logic'(k >= 32 && k <= 35));
      end
      if (k == 31) begin
        n_vec++;
        if (retry_cnt !== 8'd0) begin n_err++; $display("FAIL nolock_retry0: got %0d want 0", retry_cnt); end
      end
      if (k == 32) begin
        n_vec++;
        if (retry_cnt !== 8'd1) begin n_err++; $display("FAIL nolock_retry1: got %0d want 1", retry_cnt); end
      end
    end
    for (int p = 2; p <= 300; p++) begin
      repeat (RP + LT) tick();
      if (p == 100) begin
        n_vec++;
        if (retry_cnt !== 8'd100) begin
          n_err++; $display("FAIL nolock_retry100: got %0d want 100", retry_cnt);
        end
      end
    end
    n_vec++;
    if (retry_cnt !== 8'd255) begin n_err++; $display("FAIL nolock_saturate: got %0d want 255", retry_cnt); end
    n_vec++;
    if (pll_rst !== 1'b0) begin n_err++; $display("FAIL nolock_phase: got %b want 0", pll_rst); end
  endtask

  // force_reset arrives on the edge where the FSM first sees the synchronized lock drop.
  task automatic test_force_reset();
    bring_to_run();
    locked = 1'b0;
    tick();
    tick();
    force_reset = 1'b1;
    tick();
    force_reset = 1'b0;
    n_vec++;
    if (sys_reset_n !== 1'b0 || ready !== 1'b0) begin
      n_err++; $display("FAIL force_leave_run: got sys_reset_n=%b ready=%b want 0", sys_reset_n, ready);
    end
    n_vec++;
    if (lock_lost !== 1'b0) begin n_err++; $display("FAIL force_no_lock_lost: got %b want 0", lock_lost); end
    for (int k = 1; k <= 4; k++) begin
      n_vec++;
      if (pll_rst !== logic'(k < 4 || k == 4 && 1'b0) && k < 4) begin
        n_err++; $display("FAIL force_pll_rst cycle %0d: got %b want 1", k, pll_rst);
      end
      tick();
      n_vec++;
      if (lock_lost !== 1'b0) begin
        n_err++; $display("FAIL force_lock_lost cycle %0d: got %b want 0", k, lock_lost);
      end
    end
    n_vec++;
    if (pll_rst !== 1'b0) begin n_err++; $display("FAIL force_pll_rst_end: got %b want 0", pll_rst); end
    n_vec++;
    if (retry_cnt !== 8'd0) begin n_err++; $display("FAIL force_retry: got %0d want 0", retry_cnt); end
  endtask

  task automatic test_async_reset();
    bring_to_run();
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (pll_rst !== 1'b1 || sys_reset_n !== 1'b0 || ready !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got pll_rst=%b sys_reset_n=%b ready=%b want 1 0 0",
               pll_rst, sys_reset_n, ready);
    end
    @(negedge refclk);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_vec++;
      if (pll_rst !== logic'(k < 4)) begin
        n_err++;
        $display("FAIL async_restart cycle %0d: got %b want %b", k, pll_rst, logic'(k < 4));
      end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    locked      = 1'b0;
    force_reset = 1'b0;
    test_reset();
    test_clean_lock();
    test_lock_loss();
    test_glitch();
    test_no_lock();
    test_force_reset();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Sequencer on the consuming side of the core clock PLL. Drives the PLL's active-high `rst`, watches its `locked` output, qualifies lock stability, and issues the core's active-low system reset only after lock has been continuously held. Retries the PLL on lock timeout and re-sequences on lock loss. Runs on `refclk`, the board reference clock that also feeds the PLL, so it keeps working while PLL outputs are absent.

## Interface

Parameters:
- `RST_PULSE`, 16: refclk cycles `pll_rst` is held high per attempt (≥1).
- `LOCK_STABLE`, 1024: consecutive synchronized-locked cycles required before release (≥1).
- `LOCK_TIMEOUT`, 50000: refclk cycles to wait for lock before retrying (≥1).
- `CNT_W`, 20: shared counter width; must hold max(RST_PULSE, LOCK_STABLE, LOCK_TIMEOUT)−1.

Ports:
- `refclk` in 1: reference clock, 50 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `locked` in 1: PLL lock, asynchronous to refclk.
- `force_reset` in 1: synchronous request to restart the PLL (OSD/menu), level-sensitive.
- `pll_rst` out 1: to PLL `rst`, active high.
- `sys_reset_n` out 1: core reset, active low, registered.
- `ready` out 1: high while in RUN.
- `lock_lost` out 1: one-cycle pulse on lock loss from RUN.
- `retry_cnt` out 8: count of timeout retries, saturates at 255.

## Operation

- `locked` passes through a 2-FF synchronizer; FSM uses `locked_s` only.
- States: PLL_RST, WAIT_LOCK, STABLE, RUN. One counter `cnt`, cleared on every state entry.
- Reset (rst_n low, asynchronous): state=PLL_RST, cnt=0, sync FFs=0, `pll_rst`=1, `sys_reset_n`=0, `ready`=0, `lock_lost`=0, `retry_cnt`=0.
- PLL_RST: `pll_rst`=1. When cnt==RST_PULSE−1, go to WAIT_LOCK.
- WAIT_LOCK: `pll_rst`=0. If `locked_s`, go to STABLE. Otherwise, when cnt==LOCK_TIMEOUT−1, go to PLL_RST and increment `retry_cnt` (saturating).
- STABLE: if `!locked_s`, go to WAIT_LOCK. This is a glitch: no retry increment, and the timeout restarts. Otherwise, when cnt==LOCK_STABLE−1, go to RUN.
- RUN: `sys_reset_n`=1, `ready`=1. If `!locked_s`, go to PLL_RST and pulse `lock_lost` for one cycle.
- `force_reset` high in any state: go to PLL_RST (cnt=0) on the next edge. It has highest priority, never increments `retry_cnt`, and never pulses `lock_lost`. While held, the FSM remains in PLL_RST.
- `sys_reset_n` and `ready` are registered. They are 1 exactly when the registered state is RUN and fall on the same edge that leaves RUN.
- `pll_rst` is registered. It is 1 exactly when the registered state is PLL_RST.
- `retry_cnt` clears only on `rst_n`.

## Timing

- After `rst_n` deasserts, `pll_rst` stays high for exactly RST_PULSE refclk cycles.
- Lock acquisition, taking E0 as the first edge sampling `locked`=1 while in WAIT_LOCK:
  - `locked_s`=1 after E1.
  - STABLE entered at E2.
  - RUN entered at E(LOCK_STABLE+2).
  - `sys_reset_n`/`ready` therefore rise LOCK_STABLE+3 edges after `locked` is first sampled.
- Lock loss, taking E0 as the first edge sampling `locked`=0 in RUN: at E2, `sys_reset_n`=0, `ready`=0, `pll_rst`=1, and `lock_lost`=1. `lock_lost` returns to 0 at E3.
- WAIT_LOCK without lock lasts exactly LOCK_TIMEOUT cycles; one full retry period is RST_PULSE+LOCK_TIMEOUT cycles.
- `force_reset` sampled high at edge E0 puts the FSM in PLL_RST from E0. `pll_rst` is held for RST_PULSE cycles after the last edge sampling `force_reset` high.
- Simultaneous `force_reset` and lock loss in RUN: `force_reset` wins, so `lock_lost` stays 0.
- `rst_n` assertion mid-operation takes effect immediately and asynchronously on all outputs. Counters restart from 0 on release.

## Test plan

All scenarios use RST_PULSE=4, LOCK_STABLE=8, LOCK_TIMEOUT=32.

- Reset: hold `rst_n`=0 with `locked`=1. Required: `pll_rst`=1, `sys_reset_n`=0, `ready`=0, `retry_cnt`=0. Release `rst_n`: `pll_rst` stays high exactly 4 cycles, then drops.
- Clean lock: raise `locked` 10 cycles after `pll_rst` falls and hold it. Required: `sys_reset_n`/`ready` rise exactly 11 edges after `locked` is first sampled; `retry_cnt`=0.
- No lock: hold `locked`=0. Required:
  - `pll_rst` low for 32 cycles, high for 4 cycles, repeating.
  - `retry_cnt`=1 after the first timeout.
  - After 300 periods, `retry_cnt`=255 (saturated).
- Glitch in STABLE: `locked` high 5 cycles, low 1 cycle, then high. Required:
  - No RUN entry until 8 fresh stable cycles after the glitch.
  - `sys_reset_n` stays 0 throughout the glitch.
  - `pll_rst` stays 0.
  - `retry_cnt` unchanged.
- Lock loss in RUN: drop `locked`. Required:
  - At the 3rd edge: `sys_reset_n`=0, `ready`=0, `pll_rst`=1.
  - `lock_lost` is high for exactly one cycle.
  - Re-lock then releases `sys_reset_n` again per the clean-lock timing.
- `force_reset` in RUN on the same edge that `locked_s` falls. Required: FSM enters PLL_RST; `lock_lost` stays 0; `retry_cnt` unchanged; `pll_rst` lasts 4 cycles after `force_reset` goes low.
